// File: rtl/mod_addsub_ctrl_pkg.sv
// Shared constants for the modular add/subtract controller: operand width,
// FSM state encoding and operation codes.
package mod_addsub_ctrl_pkg;

  localparam int unsigned ADDSUB_WIDTH = 1025;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_OP1  = 3'd1;
  localparam logic [2:0] ST_W1   = 3'd2;
  localparam logic [2:0] ST_OP2  = 3'd3;
  localparam logic [2:0] ST_W2   = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    OP1  = ST_OP1,
    W1   = ST_W1,
    OP2  = ST_OP2,
    W2   = ST_W2,
    FIN  = ST_FIN
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mod_addsub_ctrl_if.sv
// Handshake bundles: requester <-> controller, and controller <-> multi-cycle adder.
interface mod_addsub_req_if
  import mod_addsub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_WIDTH
);
  logic             start;
  logic             subtract;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  modport master (output start, subtract, in_a, in_b, in_m, input result, done, busy);
  modport slave  (input start, subtract, in_a, in_b, in_m, output result, done, busy);
endinterface

interface mod_addsub_add_if
  import mod_addsub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_WIDTH
);
  logic             add_start;
  logic             add_subtract;
  logic [WIDTH-1:0] add_in_a;
  logic [WIDTH-1:0] add_in_b;
  logic [WIDTH:0]   add_result;
  logic             add_done;

  modport master (output add_start, add_subtract, add_in_a, add_in_b, input add_result, add_done);
  modport slave  (input add_start, add_subtract, add_in_a, add_in_b, output add_result, add_done);
endinterface

// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract controller: always issues two adder ops (a+/-b, then
// correction by m) and picks the result with a mux, so timing is data independent.
module mod_addsub_ctrl
  import mod_addsub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  mod_addsub_req_if.slave  req,
  mod_addsub_add_if.master add
);

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             s_msb_q, s_msb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             add_start_q, add_start_d;
  logic             add_subtract_q, add_subtract_d;
  logic [WIDTH-1:0] add_in_a_q, add_in_a_d;
  logic [WIDTH-1:0] add_in_b_q, add_in_b_d;

  // Next-state and next-output logic; outputs are set one cycle ahead so they are registered.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    m_d            = m_q;
    s_msb_d        = s_msb_q;
    result_d       = result_q;
    done_d         = 1'b0;
    busy_d         = busy_q;
    add_start_d    = 1'b0;
    add_subtract_d = add_subtract_q;
    add_in_a_d     = add_in_a_q;
    add_in_b_d     = add_in_b_q;

    case (state_q)
      IDLE: begin
        if (req.start) begin
          op_d           = req.subtract;
          m_d            = req.in_m;
          add_in_a_d     = req.in_a;
          add_in_b_d     = req.in_b;
          add_subtract_d = req.subtract;
          add_start_d    = 1'b1;
          busy_d         = 1'b1;
          state_d        = OP1;
        end else begin
          state_d = IDLE;
        end
      end
      OP1: state_d = W1;
      W1: begin
        // add_in_a now holds s[WIDTH-1:0] for the rest of the operation
        if (add.add_done) begin
          s_msb_d        = add.add_result[WIDTH];
          add_in_a_d     = add.add_result[WIDTH-1:0];
          add_in_b_d     = m_q;
          add_subtract_d = (op_q == OP_ADD) ? 1'b1 : 1'b0;
          add_start_d    = 1'b1;
          state_d        = OP2;
        end else begin
          state_d = W1;
        end
      end
      OP2: state_d = W2;
      W2: begin
        if (add.add_done) begin
          if (op_q == OP_ADD) begin
            result_d = add.add_result[WIDTH] ? add_in_a_q : add.add_result[WIDTH-1:0];
          end else begin
            result_d = s_msb_q ? add.add_result[WIDTH-1:0] : add_in_a_q;
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FIN;
        end else begin
          state_d = W2;
        end
      end
      FIN: state_d = IDLE;
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      op_q           <= OP_ADD;
      m_q            <= '0;
      s_msb_q        <= 1'b0;
      result_q       <= '0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      add_start_q    <= 1'b0;
      add_subtract_q <= 1'b0;
      add_in_a_q     <= '0;
      add_in_b_q     <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      m_q            <= m_d;
      s_msb_q        <= s_msb_d;
      result_q       <= result_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      add_start_q    <= add_start_d;
      add_subtract_q <= add_subtract_d;
      add_in_a_q     <= add_in_a_d;
      add_in_b_q     <= add_in_b_d;
    end
  end

  assign req.result       = result_q;
  assign req.done         = done_q;
  assign req.busy         = busy_q;
  assign add.add_start    = add_start_q;
  assign add.add_subtract = add_subtract_q;
  assign add.add_in_a     = add_in_a_q;
  assign add.add_in_b     = add_in_b_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Directed bench for mod_addsub_ctrl with a behavioural multi-cycle adder.
module tb_mod_addsub_ctrl;
  import mod_addsub_ctrl_pkg::*;

  localparam int unsigned W  = ADDSUB_WIDTH;
  localparam int unsigned WX = W + 1;
  localparam int          LAT = 3;
  // done appears this many sampling points after the accepting edge (2 x 4-cycle adder + 3)
  localparam int          EXP_DONE_K = 11;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n_start = 0;

  mod_addsub_req_if #(.WIDTH(W)) req_if();
  mod_addsub_add_if #(.WIDTH(W)) add_if();

  mod_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .req    (req_if),
    .add    (add_if)
  );

  always #5 clk = ~clk;

  logic         m_busy;
  int           m_cnt;
  logic [W-1:0] m_a, m_b;
  logic         m_sub;

  // Behavioural adder: samples operands on add_start while idle, answers LAT+1 cycles later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 1'b0; m_cnt <= 0; m_a <= '0; m_b <= '0; m_sub <= 1'b0;
      add_if.add_done <= 1'b0; add_if.add_result <= '0;
    end else begin
      add_if.add_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          add_if.add_done   <= 1'b1;
          add_if.add_result <= m_sub ? ({1'b0, m_a} - {1'b0, m_b}) : ({1'b0, m_a} + {1'b0, m_b});
          m_busy <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (add_if.add_start) begin
        m_busy <= 1'b1; m_cnt <= LAT;
        m_a <= add_if.add_in_a; m_b <= add_if.add_in_b; m_sub <= add_if.add_subtract;
      end
    end
  end

  // Counts add_start pulses seen by the adder.
  always_ff @(posedge clk) begin
    if (add_if.add_start) n_start <= n_start + 1;
  end

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                        input logic sub, input logic [W-1:0] exp, input string tag,
                        input bit inj_w1, input bit inj_fin);
    int done_k;
    int st0;
    done_k = 0;
    @(negedge clk);
    req_if.in_a = a; req_if.in_b = b; req_if.in_m = m;
    req_if.subtract = sub; req_if.start = 1'b1;
    st0 = n_start;
    for (int k = 1; k <= 60 && done_k == 0; k++) begin
      @(negedge clk);
      req_if.start = (inj_w1 && k == 3) ? 1'b1 : 1'b0;
      if (inj_w1 && k == 3) begin
        req_if.in_a = ~a; req_if.in_b = ~b; req_if.in_m = ~m; req_if.subtract = ~sub;
      end
      if (k == 1) begin
        chk({tag, "_busy"}, WX'(req_if.busy), WX'(1'b1));
        chk({tag, "_op1_start"}, WX'(add_if.add_start), WX'(1'b1));
        chk({tag, "_op1_a"}, WX'(add_if.add_in_a), WX'(a));
        chk({tag, "_op1_b"}, WX'(add_if.add_in_b), WX'(b));
        chk({tag, "_op1_sub"}, WX'(add_if.add_subtract), WX'(sub));
      end
      if (k == 6) begin
        chk({tag, "_op2_start"}, WX'(add_if.add_start), WX'(1'b1));
        chk({tag, "_op2_b"}, WX'(add_if.add_in_b), WX'(m));
        chk({tag, "_op2_sub"}, WX'(add_if.add_subtract), WX'(!sub));
      end
      if (req_if.done) begin
        done_k = k;
        chk({tag, "_result"}, WX'(req_if.result), WX'(exp));
        chk({tag, "_busy_at_done"}, WX'(req_if.busy), WX'(1'b0));
      end
    end
    chk({tag, "_latency"}, WX'(done_k), WX'(EXP_DONE_K));
    if (inj_fin) req_if.start = 1'b1;
    @(negedge clk);
    req_if.start = 1'b0;
    chk({tag, "_done_pulse"}, WX'(req_if.done), WX'(1'b0));
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_idle_busy"}, WX'(req_if.busy), WX'(1'b0));
    chk({tag, "_nstart"}, WX'(n_start - st0), WX'(2));
    chk({tag, "_result_hold"}, WX'(req_if.result), WX'(exp));
  endtask

  initial begin
    logic [W-1:0] mbig;
    int seen_done;
    int st0;
    mbig = {1'b0, {(W-1){1'b1}}};
    req_if.start = 1'b0; req_if.subtract = 1'b0;
    req_if.in_a = '0; req_if.in_b = '0; req_if.in_m = '0;

    @(negedge clk);
    chk("rst_result", WX'(req_if.result), WX'(0));
    chk("rst_done", WX'(req_if.done), WX'(0));
    chk("rst_busy", WX'(req_if.busy), WX'(0));
    chk("rst_add_start", WX'(add_if.add_start), WX'(0));
    chk("rst_add_sub", WX'(add_if.add_subtract), WX'(0));
    chk("rst_add_a", WX'(add_if.add_in_a), WX'(0));
    chk("rst_add_b", WX'(add_if.add_in_b), WX'(0));
    @(negedge clk);
    resetn = 1'b1;

    run_op(5, 7, 11, OP_ADD, 1, "add_wrap", 1'b0, 1'b0);
    run_op(3, 4, 11, OP_ADD, 7, "add_nowrap", 1'b0, 1'b0);
    run_op(3, 7, 11, OP_SUB, 7, "sub_borrow", 1'b0, 1'b0);
    run_op(7, 3, 11, OP_SUB, 4, "sub_plain", 1'b0, 1'b0);
    run_op(9, 9, 11, OP_SUB, 0, "sub_zero", 1'b0, 1'b0);
    run_op(mbig - 1, mbig - 1, mbig, OP_ADD, mbig - 2, "add_full", 1'b0, 1'b0);
    run_op(2, 6, 11, OP_ADD, 8, "start_ignored", 1'b1, 1'b1);

    // Reset while the second adder op is in flight.
    @(negedge clk);
    req_if.in_a = 5; req_if.in_b = 7; req_if.in_m = 11;
    req_if.subtract = OP_ADD; req_if.start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_if.start = 1'b0;
    end
    chk("pre_rst_busy", WX'(req_if.busy), WX'(1'b1));
    resetn = 1'b0;
    #1;
    chk("mid_rst_result", WX'(req_if.result), WX'(0));
    chk("mid_rst_done", WX'(req_if.done), WX'(0));
    chk("mid_rst_busy", WX'(req_if.busy), WX'(0));
    chk("mid_rst_add_start", WX'(add_if.add_start), WX'(0));
    chk("mid_rst_add_sub", WX'(add_if.add_subtract), WX'(0));
    chk("mid_rst_add_a", WX'(add_if.add_in_a), WX'(0));
    chk("mid_rst_add_b", WX'(add_if.add_in_b), WX'(0));
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    seen_done = 0;
    st0 = n_start;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (req_if.done) seen_done++;
    end
    chk("post_rst_no_done", WX'(seen_done), WX'(0));
    chk("post_rst_no_start", WX'(n_start - st0), WX'(0));

    run_op(1, 1, 11, OP_ADD, 2, "after_reset", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
